// File: rtl/game_timer_pkg.sv
// Shared types and constants for the Bricks round timer.
package game_timer_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    PLAY      = 3'd2,
    PAUSED    = 3'd3,
    WON       = 3'd4,
    LOST      = 3'd5
  } state_t;

  localparam int unsigned SEC_W_DEFAULT = 8;
  localparam int unsigned TENTHS        = 10;
  localparam int unsigned TENTH_W       = $clog2(TENTHS);

endpackage

// File: rtl/game_timer_ctrl_tick_divider.sv
// Mod-10 tenth counter: turns turbo ticks back into whole game seconds.
module tick_divider
  import game_timer_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic wrap
);

  localparam logic [TENTH_W-1:0] LAST = TENTH_W'(TENTHS - 1);

  logic [TENTH_W-1:0] tenth_q;
  logic [TENTH_W-1:0] tenth_d;

  // wrap reflects the tick being counted now, even if clear also fires this cycle
  assign wrap = enable && (tenth_q == LAST);

  always_comb begin
    tenth_d = tenth_q;
    if (clear) begin
      tenth_d = '0;
    end else if (enable) begin
      tenth_d = (tenth_q == LAST) ? '0 : tenth_q + TENTH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tenth_q <= '0;
    end else begin
      tenth_q <= tenth_d;
    end
  end

endmodule

// File: rtl/game_timer_ctrl.sv
// Round sequencer for Bricks: states, seconds-left clock, counter restart and turbo control.
module game_timer_ctrl
  import game_timer_pkg::*;
#(
  parameter int unsigned SEC_W             = SEC_W_DEFAULT,
  parameter int unsigned GAME_SECONDS      = 90,
  parameter int unsigned COUNTDOWN_SECONDS = 3,
  parameter int unsigned WARN_SECONDS      = 10,
  parameter int unsigned BONUS_SECONDS     = 10,
  parameter int unsigned MAX_SECONDS       = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_game,
  input  logic             pause_toggle,
  input  logic             add_bonus,
  input  logic             level_cleared,
  input  logic             lives_zero,
  input  logic             one_sec,
  output logic             timer_startN,
  output logic             turbo,
  output state_t           state,
  output logic [SEC_W-1:0] seconds_left,
  output logic             time_up,
  output logic             game_active
);

  localparam logic [SEC_W-1:0] GAME_S = SEC_W'(GAME_SECONDS);
  localparam logic [SEC_W-1:0] CD_S   = SEC_W'(COUNTDOWN_SECONDS);
  localparam logic [SEC_W-1:0] WARN_S = SEC_W'(WARN_SECONDS);
  localparam logic [SEC_W-1:0] MAX_S  = SEC_W'(MAX_SECONDS);
  localparam logic [SEC_W-1:0] ONE_S  = SEC_W'(1);

  state_t           state_q, state_d;
  logic [SEC_W-1:0] seconds_q, seconds_d;
  logic             timer_startn_q, timer_startn_d;
  logic             mask_dly_q, mask_dly_d;
  logic             turbo_q, turbo_d;
  logic             time_up_q, time_up_d;
  logic             game_active_q, game_active_d;

  logic             tick_mask;
  logic             tick_ok;
  logic             tick_wrap;
  logic             second_evt;
  logic             restart;
  logic             tenth_clr;
  logic [SEC_W-1:0] sec_dec;
  logic [SEC_W-1:0] bonus_base;
  logic [SEC_W-1:0] sec_bonus;
  logic [31:0]      bonus_sum;

  // The counter emits a spurious pulse after restart: mask the pulse cycle and the one after.
  assign tick_mask  = !timer_startn_q || mask_dly_q;
  assign tick_ok    = one_sec && !tick_mask;
  assign second_evt = turbo_q ? tick_wrap : tick_ok;

  tick_divider u_tick_divider (
    .clk    (clk),
    .reset  (reset),
    .clear  (tenth_clr),
    .enable (tick_ok && turbo_q),
    .wrap   (tick_wrap)
  );

  always_comb begin
    sec_dec    = (second_evt && (seconds_q != '0)) ? seconds_q - ONE_S : seconds_q;
    bonus_base = (state_q == PLAY) ? sec_dec : seconds_q;
    bonus_sum  = 32'(bonus_base) + BONUS_SECONDS;
    sec_bonus  = (bonus_sum > MAX_SECONDS) ? MAX_S : SEC_W'(bonus_sum);
  end

  always_comb begin
    state_d   = state_q;
    seconds_d = seconds_q;
    restart   = 1'b0;
    time_up_d = 1'b0;

    case (state_q)
      IDLE, WON, LOST: begin
        if (start_game) begin
          state_d   = COUNTDOWN;
          seconds_d = CD_S;
          restart   = 1'b1;
        end
      end

      COUNTDOWN: begin
        if (second_evt) begin
          if (seconds_q == ONE_S) begin
            state_d   = PLAY;
            seconds_d = GAME_S;
            restart   = 1'b1;
          end else begin
            seconds_d = sec_dec;
          end
        end
      end

      PLAY: begin
        if (lives_zero) begin
          state_d = LOST;
        end else if (level_cleared) begin
          state_d = WON;
        end else begin
          seconds_d = add_bonus ? sec_bonus : sec_dec;
          // a bonus landing on the final second rescues the round
          if (!add_bonus && second_evt && (sec_dec == '0)) begin
            state_d   = LOST;
            time_up_d = 1'b1;
          end else if (pause_toggle) begin
            state_d = PAUSED;
          end
        end
      end

      PAUSED: begin
        if (lives_zero) begin
          state_d = LOST;
        end else begin
          if (add_bonus) begin
            seconds_d = sec_bonus;
          end
          if (pause_toggle) begin
            state_d = PLAY;
            restart = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    turbo_d        = (state_d == PLAY) && (seconds_d <= WARN_S);
    tenth_clr      = restart || (turbo_q && !turbo_d);
    timer_startn_d = !restart;
    mask_dly_d     = !timer_startn_q;
    game_active_d  = (state_d == PLAY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      seconds_q      <= '0;
      timer_startn_q <= 1'b1;
      mask_dly_q     <= 1'b0;
      turbo_q        <= 1'b0;
      time_up_q      <= 1'b0;
      game_active_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      seconds_q      <= seconds_d;
      timer_startn_q <= timer_startn_d;
      mask_dly_q     <= mask_dly_d;
      turbo_q        <= turbo_d;
      time_up_q      <= time_up_d;
      game_active_q  <= game_active_d;
    end
  end

  assign state        = state_q;
  assign seconds_left = seconds_q;
  assign timer_startN = timer_startn_q;
  assign turbo        = turbo_q;
  assign time_up      = time_up_q;
  assign game_active  = game_active_q;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Randomized and directed bench for game_timer_ctrl against a behavioural round model.
module tb_game_timer_ctrl;
  import game_timer_pkg::*;

  localparam int GAME  = 5;
  localparam int CD    = 3;
  localparam int WARN  = 2;
  localparam int BONUS = 4;
  localparam int MAXS  = 7;

  localparam logic [5:0] ST = 6'b100000;
  localparam logic [5:0] PT = 6'b010000;
  localparam logic [5:0] AB = 6'b001000;
  localparam logic [5:0] LC = 6'b000100;
  localparam logic [5:0] LZ = 6'b000010;
  localparam logic [5:0] OS = 6'b000001;
  localparam logic [5:0] NO = 6'b000000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_game = 1'b0, pause_toggle = 1'b0, add_bonus = 1'b0;
  logic       level_cleared = 1'b0, lives_zero = 1'b0, one_sec = 1'b0;
  logic       timer_startN, turbo, time_up, game_active;
  state_t     state;
  logic [7:0] seconds_left;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  // model of the round
  state_t m_state = IDLE;
  int     m_sec = 0, m_tenth = 0, m_mask = 0;
  bit     m_startn = 1'b1, m_turbo = 1'b0, m_timeup = 1'b0, m_active = 1'b0;

  always #5 clk = ~clk;

  game_timer_ctrl #(
    .SEC_W             (8),
    .GAME_SECONDS      (GAME),
    .COUNTDOWN_SECONDS (CD),
    .WARN_SECONDS      (WARN),
    .BONUS_SECONDS     (BONUS),
    .MAX_SECONDS       (MAXS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start_game    (start_game),
    .pause_toggle  (pause_toggle),
    .add_bonus     (add_bonus),
    .level_cleared (level_cleared),
    .lives_zero    (lives_zero),
    .one_sec       (one_sec),
    .timer_startN  (timer_startN),
    .turbo         (turbo),
    .state         (state),
    .seconds_left  (seconds_left),
    .time_up       (time_up),
    .game_active   (game_active)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_step();
    bit     tick, sec_evt, restart;
    int     nsec;
    state_t ns;
    if (reset) begin
      m_state = IDLE; m_sec = 0; m_tenth = 0; m_mask = 0;
      m_startn = 1'b1; m_turbo = 1'b0; m_timeup = 1'b0; m_active = 1'b0;
      return;
    end
    tick = one_sec && (m_mask == 0);
    if (m_mask > 0) m_mask--;
    sec_evt = 1'b0;
    if (tick) begin
      if (m_turbo) begin
        m_tenth = (m_tenth + 1) % 10;
        sec_evt = (m_tenth == 0);
      end else begin
        sec_evt = 1'b1;
      end
    end
    ns = m_state; nsec = m_sec; restart = 1'b0; m_timeup = 1'b0;
    case (m_state)
      IDLE, WON, LOST:
        if (start_game) begin ns = COUNTDOWN; nsec = CD; restart = 1'b1; end
      COUNTDOWN:
        if (sec_evt) begin
          if (m_sec == 1) begin ns = PLAY; nsec = GAME; restart = 1'b1; end
          else if (m_sec > 0) nsec = m_sec - 1;
        end
      PLAY:
        if (lives_zero) ns = LOST;
        else if (level_cleared) ns = WON;
        else begin
          nsec = (sec_evt && m_sec > 0) ? m_sec - 1 : m_sec;
          if (add_bonus) nsec = min2(nsec + BONUS, MAXS);
          else if (sec_evt && nsec == 0) begin ns = LOST; m_timeup = 1'b1; end
          if (ns == PLAY && pause_toggle) ns = PAUSED;
        end
      PAUSED:
        if (lives_zero) ns = LOST;
        else begin
          if (add_bonus) nsec = min2(m_sec + BONUS, MAXS);
          if (pause_toggle) begin ns = PLAY; restart = 1'b1; end
        end
      default: ns = IDLE;
    endcase
    if (restart) begin m_tenth = 0; m_mask = 2; end
    if (m_turbo && !(ns == PLAY && nsec <= WARN)) m_tenth = 0;
    m_state  = ns;
    m_sec    = nsec;
    m_turbo  = (ns == PLAY) && (nsec <= WARN);
    m_startn = !restart;
    m_active = (ns == PLAY);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("state",        int'(state),        int'(m_state));
      chk("seconds_left", int'(seconds_left), m_sec);
      chk("timer_startN", int'(timer_startN), int'(m_startn));
      chk("turbo",        int'(turbo),        int'(m_turbo));
      chk("time_up",      int'(time_up),      int'(m_timeup));
      chk("game_active",  int'(game_active),  int'(m_active));
    end
  end

  task automatic step(input logic [5:0] v);
    {start_game, pause_toggle, add_bonus, level_cleared, lives_zero, one_sec} = v;
    @(negedge clk);
  endtask

  task automatic goto_play();
    step(ST); step(NO); step(NO);
    repeat (3) step(OS);
    step(NO); step(NO);
  endtask

  initial begin
    @(negedge clk); @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_state", int'(state), int'(IDLE));
    chk("rst_sec", int'(seconds_left), 0);
    chk("rst_startN", int'(timer_startN), 1);
    chk("rst_turbo", int'(turbo), 0);
    reset = 1'b0;

    // start and countdown with the two masked cycles
    step(ST);
    chk("t1_state", int'(state), int'(COUNTDOWN));
    chk("t1_sec", int'(seconds_left), 3);
    chk("t1_startN", int'(timer_startN), 0);
    step(OS); chk("t1_mask1", int'(seconds_left), 3);
    step(OS); chk("t1_mask2", int'(seconds_left), 3);
    step(OS); chk("t1_cd2", int'(seconds_left), 2);
    step(OS); step(OS);
    chk("t1_play", int'(state), int'(PLAY));
    chk("t1_play_sec", int'(seconds_left), 5);
    chk("t1_play_startN", int'(timer_startN), 0);
    chk("model_t1_sec", m_sec, 5);

    // normal ticks then turbo-divided ticks down to timeout
    step(OS); step(OS);
    repeat (3) step(OS);
    chk("t2_sec2", int'(seconds_left), 2);
    chk("t2_turbo", int'(turbo), 1);
    repeat (9) step(OS);
    chk("t2_hold2", int'(seconds_left), 2);
    step(OS);
    chk("t2_sec1", int'(seconds_left), 1);
    repeat (10) step(OS);
    chk("t2_lost", int'(state), int'(LOST));
    chk("t2_time_up", int'(time_up), 1);
    chk("t2_turbo_off", int'(turbo), 0);
    step(NO);
    chk("t2_time_up_pulse", int'(time_up), 0);

    // bonus saturation, and bonus rescuing the final second
    goto_play();
    step(AB);
    chk("t3_sat", int'(seconds_left), 7);
    repeat (5) step(OS);
    repeat (10) step(OS);
    chk("t3_sec1", int'(seconds_left), 1);
    repeat (9) step(OS);
    step(AB | OS);
    chk("t3_rescue_sec", int'(seconds_left), 4);
    chk("t3_rescue_state", int'(state), int'(PLAY));
    chk("t3_no_time_up", int'(time_up), 0);
    chk("t3_turbo", int'(turbo), 0);
    chk("model_t3_tenth", m_tenth, 0);

    // pause holds time; resume restarts the counter
    step(PT);
    chk("t4_paused", int'(state), int'(PAUSED));
    repeat (20) step(OS);
    chk("t4_hold", int'(seconds_left), 4);
    step(PT);
    chk("t4_resume", int'(state), int'(PLAY));
    chk("t4_startN", int'(timer_startN), 0);
    step(OS); step(OS);
    chk("t4_masked", int'(seconds_left), 4);
    step(OS);
    chk("t4_dec", int'(seconds_left), 3);

    // priority and end-of-round
    step(LZ | LC | OS);
    chk("t5_lost", int'(state), int'(LOST));
    chk("t5_frozen", int'(seconds_left), 3);
    goto_play();
    step(LC | OS);
    chk("t5_won", int'(state), int'(WON));
    step(ST);
    chk("t5_restart", int'(state), int'(COUNTDOWN));
    chk("t5_cd_sec", int'(seconds_left), 3);

    // reset mid-round
    step(NO); step(NO);
    repeat (3) step(OS);
    step(NO); step(NO);
    step(OS); step(OS);
    chk("t6_sec3", int'(seconds_left), 3);
    reset = 1'b1;
    step(NO);
    chk("t6_state", int'(state), int'(IDLE));
    chk("t6_sec", int'(seconds_left), 0);
    chk("t6_time_up", int'(time_up), 0);
    chk("t6_active", int'(game_active), 0);
    reset = 1'b0;

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic [5:0] v;
      reset  = ($urandom_range(0, 299) == 0);
      v[5]   = ($urandom_range(0, 19) == 0);
      v[4]   = ($urandom_range(0, 29) == 0);
      v[3]   = ($urandom_range(0, 24) == 0);
      v[2]   = ($urandom_range(0, 149) == 0);
      v[1]   = ($urandom_range(0, 149) == 0);
      v[0]   = ($urandom_range(0, 9) < 5);
      step(v);
    end
    reset = 1'b0;
    step(NO);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
